// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a 32-bit word RAM; bring-up stand-in for the DDR3 controller.
// Independent write and read engines, one outstanding burst each, IDs echoed.
`timescale 1ns/1ps
module axi_ram_responder #(
  parameter int ADDR_W = 28,
  parameter int DEPTH  = 1024,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              clk_resetn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH);

  // addr carries one spare MSB so an INCR carry out of ADDR_W reads as out of range
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ADDR_W:0] addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } req_t;

  function automatic logic beat_err(input req_t r);
    return (r.addr[ADDR_W:2] >= DEPTH_L) || (r.size != 3'b010) || r.burst[1];
  endfunction

  function automatic logic [ADDR_W:0] next_addr(input req_t r);
    return (r.burst == 2'b01) ? r.addr + (ADDR_W+1)'(4) : r.addr;
  endfunction

  logic [31:0] mem [DEPTH];

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t    ws, ws_nxt;
  req_t       wr;
  logic [7:0] w_cnt;
  logic       w_err, w_hs, w_last_cnt, w_end, w_beat_err, w_err_nxt;

  assign s_axi_awready = (ws == W_IDLE);
  assign s_axi_wready  = (ws == W_DATA);
  assign s_axi_bvalid  = (ws == W_RESP);

  assign w_hs       = s_axi_wvalid && (ws == W_DATA);
  assign w_last_cnt = (w_cnt == wr.len);
  assign w_end      = w_last_cnt || s_axi_wlast;
  assign w_beat_err = beat_err(wr);
  assign w_err_nxt  = w_err || w_beat_err || (s_axi_wlast != w_last_cnt);

  always_comb begin
    ws_nxt = ws;
    case (ws)
      W_IDLE:  if (s_axi_awvalid)  ws_nxt = W_DATA;
      W_DATA:  if (w_hs && w_end)  ws_nxt = W_RESP;
      W_RESP:  if (s_axi_bready)   ws_nxt = W_IDLE;
      default:                     ws_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clk_resetn) begin
      ws          <= W_IDLE;
      wr          <= '0;
      w_cnt       <= '0;
      w_err       <= 1'b0;
      s_axi_bid   <= '0;
      s_axi_bresp <= 2'b00;
    end else begin
      ws <= ws_nxt;
      if (ws == W_IDLE && s_axi_awvalid) begin
        wr    <= '{id: s_axi_awid, addr: {1'b0, s_axi_awaddr}, len: s_axi_awlen,
                   size: s_axi_awsize, burst: s_axi_awburst};
        w_cnt <= '0;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        w_cnt   <= w_cnt + 8'd1;
        wr.addr <= next_addr(wr);
        w_err   <= w_err_nxt;
        if (w_end) begin
          s_axi_bid   <= wr.id;
          s_axi_bresp <= w_err_nxt ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // RAM is deliberately not reset; a beat coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (clk_resetn && w_hs && !w_beat_err)
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) mem[wr.addr[IDX_W+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
  end

  // ---------------- read engine ----------------
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
  rstate_t    rs, rs_nxt;
  req_t       rd;
  logic [7:0] r_cnt;
  logic       r_beat_err;

  assign s_axi_arready = (rs == R_IDLE);
  assign s_axi_rvalid  = (rs == R_DATA);
  assign r_beat_err    = beat_err(rd);

  always_comb begin
    rs_nxt = rs;
    case (rs)
      R_IDLE:  if (s_axi_arvalid) rs_nxt = R_FETCH;
      R_FETCH:                    rs_nxt = R_DATA;
      R_DATA:  if (s_axi_rready)  rs_nxt = s_axi_rlast ? R_IDLE : R_FETCH;
      default:                    rs_nxt = R_IDLE;
    endcase
  end

  // the fetch samples mem with a non-blocking read, so a same-cycle write returns old data
  always_ff @(posedge clk) begin
    if (!clk_resetn) begin
      rs          <= R_IDLE;
      rd          <= '0;
      r_cnt       <= '0;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      s_axi_rlast <= 1'b0;
    end else begin
      rs <= rs_nxt;
      if (rs == R_IDLE && s_axi_arvalid) begin
        rd    <= '{id: s_axi_arid, addr: {1'b0, s_axi_araddr}, len: s_axi_arlen,
                   size: s_axi_arsize, burst: s_axi_arburst};
        r_cnt <= '0;
      end
      if (rs == R_FETCH) begin
        s_axi_rid   <= rd.id;
        s_axi_rlast <= (r_cnt == rd.len);
        s_axi_rresp <= r_beat_err ? 2'b10 : 2'b00;
        s_axi_rdata <= r_beat_err ? 32'h0 : mem[rd.addr[IDX_W+1:2]];
      end
      if (rs == R_DATA && s_axi_rready && !s_axi_rlast) begin
        r_cnt   <= r_cnt + 8'd1;
        rd.addr <= next_addr(rd);
      end
    end
  end
endmodule
